// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard for RAW/WAW hazard detection.
// Combinational reads with optional write bypass; writes and issues take effect on iClk rise.
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [ADDR_W-1:0] iAddrA,
    input  logic [ADDR_W-1:0] iAddrB,
    output logic [WIDTH-1:0]  oRegA,
    output logic [WIDTH-1:0]  oRegB,
    output logic              oBusyA,
    output logic              oBusyB,
    input  logic              iWrite,
    input  logic [ADDR_W-1:0] iAddrC,
    input  logic [WIDTH-1:0]  iRegC,
    input  logic              iIssue,
    input  logic [ADDR_W-1:0] iIssueAddr,
    output logic              oIssueReady,
    output logic [ADDR_W:0]   oPendCnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  pend_q, pend_d;

    logic wr_en;
    logic issue_zero;
    logic issue_ready;
    logic issue_set;
    logic pend_inc;
    logic pend_dec;

    always_comb begin
        wr_en       = iWrite && !(ZERO_REG && (iAddrC == '0));
        issue_zero  = ZERO_REG && (iIssueAddr == '0);
        issue_ready = issue_zero || !busy_q[iIssueAddr] || (iWrite && (iAddrC == iIssueAddr));
        issue_set   = iIssue && issue_ready && !issue_zero;
        pend_inc    = issue_set && !busy_q[iIssueAddr];
        // A same-address issue keeps the bit set, so the write must not count it as cleared.
        pend_dec    = wr_en && busy_q[iAddrC] && !(issue_set && (iIssueAddr == iAddrC));
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[iAddrC] = iRegC;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[iAddrC] = 1'b0;
        end
        if (issue_set) begin
            busy_d[iIssueAddr] = 1'b1;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (pend_inc && !pend_dec) begin
            pend_d = pend_q + (ADDR_W+1)'(1);
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        oRegA = mem_q[iAddrA];
        if (BYPASS && wr_en && (iAddrC == iAddrA)) begin
            oRegA = iRegC;
        end
        if (ZERO_REG && (iAddrA == '0)) begin
            oRegA = '0;
        end

        oRegB = mem_q[iAddrB];
        if (BYPASS && wr_en && (iAddrC == iAddrB)) begin
            oRegB = iRegC;
        end
        if (ZERO_REG && (iAddrB == '0)) begin
            oRegB = '0;
        end

        oBusyA = busy_q[iAddrA] && !(BYPASS && wr_en && (iAddrC == iAddrA));
        oBusyB = busy_q[iAddrB] && !(BYPASS && wr_en && (iAddrC == iAddrB));
    end

    assign oIssueReady = issue_ready;
    assign oPendCnt    = pend_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with an integrated register scoreboard. It is the next generation of the CPU register bank. It adds configurable width and depth, a hard-wired zero register, a write-to-read bypass, and per-register busy tracking. The decode stage uses the busy tracking to detect RAW/WAW hazards against in-flight instructions. It sits between decode (read and issue ports) and writeback (write port).

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; power of two, 2..64; ADDR_W = log2(DEPTH)
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issues
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports and the busy outputs
- iClk  in  1  clock, rising-edge active
- iRst  in  1  asynchronous, active-high reset
- iAddrA  in  ADDR_W  read port A address
- iAddrB  in  ADDR_W  read port B address
- oRegA  out  WIDTH  read port A data
- oRegB  out  WIDTH  read port B data
- oBusyA  out  1  register at iAddrA has a pending write
- oBusyB  out  1  register at iAddrB has a pending write
- iWrite  in  1  writeback strobe
- iAddrC  in  ADDR_W  writeback address
- iRegC  in  WIDTH  writeback data
- iIssue  in  1  request to mark iIssueAddr as pending
- iIssueAddr  in  ADDR_W  destination register of the issuing instruction
- oIssueReady  out  1  an issue to iIssueAddr will be accepted this cycle
- oPendCnt  out  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: DEPTH x WIDTH flops plus a busy[DEPTH] vector and a pending counter.
- Write: on iClk rise with iWrite=1, mem[iAddrC] <= iRegC.
  - Ignored when ZERO_REG=1 and iAddrC=0.
  - Clears busy[iAddrC] unless the same-cycle issue rule below applies.
- Read (combinational): oRegX = mem[iAddrX].
  - When ZERO_REG=1 and iAddrX=0, the output is 0.
  - When BYPASS=1, iWrite=1, iAddrC=iAddrX and the write is not suppressed, the output is iRegC.
- oBusyX = busy[iAddrX].
  - When BYPASS=1, forced to 0 when a non-suppressed write to iAddrX occurs the same cycle.
- oIssueReady = ~busy[iIssueAddr] | (iWrite & iAddrC==iIssueAddr).
  - Always 1 for address 0 when ZERO_REG=1.
- Issue is accepted when iIssue & oIssueReady.
  - Accepted issue sets busy[iIssueAddr]; for address 0 with ZERO_REG=1 it is accepted but is a no-op.
  - An issue presented while oIssueReady=0 is dropped, with no state change. Decode must hold iIssue until it sees ready.
- Same address issued and written in one cycle: the issue wins. busy stays or becomes 1, and the data is still written.
- oPendCnt is incremented by an accepted issue that sets a bit which was previously clear.
- oPendCnt is decremented by a write that clears a set bit.
- Same-address issue and write on a busy bit: net change 0. Different addresses: independent +1/-1.
- oPendCnt never exceeds DEPTH, or DEPTH-1 when ZERO_REG=1.
- Write to a non-busy register: data updated, no counter change.

## Timing
- Reset, asynchronous on iRst rising, held while high:
  - all mem = 0, busy = 0, oPendCnt = 0
  - hence oRegA/B = 0, oBusyA/B = 0, oIssueReady = 1
- iRst asserted mid-operation discards all pending state immediately, not waiting for a clock edge.
- First write accepted on the first iClk rise after iRst deasserts.
- Read latency 0, combinational.
- Without bypass, written data is visible the cycle after the write edge.
- busy set and oPendCnt update are visible the cycle after the accepting edge.
- No handshake back-pressure on the write port: every iWrite is consumed on its edge.

## Test plan
- Reset, then read all addresses on A and B: 0 everywhere, oBusy 0, oPendCnt 0, oIssueReady 1. Assert iRst mid-stream after writes: all 0 asynchronously.
- Write 0xDEADBEEF to r5 and r0. Next cycle, A=5 reads 0xDEADBEEF; B=0 reads 0 (ZERO_REG=1).
- Bypass: iWrite r7=0x12345678 with iAddrA=7 in the same cycle. oRegA=0x12345678 combinationally. With BYPASS=0, oRegA shows the old value until the next cycle.
- Scoreboard: issue r3, then next cycle oBusyA(A=3)=1 and oPendCnt=1. Issue r3 again: oIssueReady=0, dropped, count stays 1. Write r3: busy clears, count 0.
- Simultaneous: r4 busy, same cycle write r4 plus issue r4. Data written, busy stays 1, count unchanged. Issue r6 plus write to busy r9 in one cycle: count unchanged, busy r6=1, busy r9=0.
- Fill: issue every register 1..31 on consecutive cycles. oPendCnt reaches 31; issue r0 is accepted and the count stays 31.
